dual_port_ram_param: RTL and testbench
======================================

Name: dual_port_ram_param

Overview:
- Parametrised true dual-port synchronous RAM; next generation of the team's fixed 32x8 dual-port RAM.
- Adds configurable width and depth, per-port enables, and selectable read-during-write mode.
- Defined cross-port collision handling with a flag output.
- Sequential post-reset initialisation sweep that clears every location.
- Used as shared scratch/buffer memory between two independent masters in one clock domain.

Parameters:
DATA_W, 8, data width in bits per word
ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
RD_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
INIT_VAL, 0, value written to every word by the init sweep (DATA_W bits, truncated)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
en_a  in  1  port A access enable
wr_a  in  1  port A write (valid only with en_a=1)
addr_a  in  ADDR_W  port A address
data_a  in  DATA_W  port A write data
q_a  out  DATA_W  port A registered read data
en_b  in  1  port B access enable
wr_b  in  1  port B write (valid only with en_b=1)
addr_b  in  ADDR_W  port B address
data_b  in  DATA_W  port B write data
q_b  out  DATA_W  port B registered read data
init_busy  out  1  high while init sweep runs; port requests ignored
collision  out  1  one-cycle pulse: same-address conflict accepted on previous edge

Behaviour:
- Reset (reset=1 at an edge): q_a=0, q_b=0, collision=0, init_busy=1, init counter=0, FSM -> INIT. Reset held keeps this state and does not advance the counter.
- FSM states: INIT, RUN.
- INIT: each edge with reset=0 writes INIT_VAL to mem[cnt] and increments cnt. The edge that writes address DEPTH-1 moves to RUN and clears init_busy. The sweep takes exactly DEPTH cycles after reset release.
- During INIT: en/wr inputs ignored, no memory writes from ports, q_a/q_b held at 0, collision=0.
- RUN, per port X, when en_X=1:
  - wr_X=1: mem[addr_X] <= data_X at the edge.
  - q_X updates at the same edge; read latency is 1 cycle.
  - Write cycle: q_X = old word if RD_MODE=0, data_X if RD_MODE=1.
  - Read-only cycle: q_X = mem[addr_X].
- en_X=0: no access; q_X holds its last value. wr_X is ignored when en_X=0.
- Cross-port, same address, both enabled:
  - Both write: port A data wins and is stored; collision=1 next cycle.
  - One port writes, the other reads: the reading port returns the old word regardless of RD_MODE; the writing port follows RD_MODE; collision=1 next cycle.
  - Both read: both get the same word; collision=0.
- collision is registered, high for exactly one cycle per conflicting edge. It stays high across consecutive conflicting edges.
- Reset asserted in RUN: aborts all access and restarts INIT. All memory is re-cleared and no prior contents survive.
- Address range is exactly DEPTH; no out-of-range case exists.

Optional Feature:
- Macro OUTPUT_REG_EN.
- Defined: adds one pipeline register stage after q_a/q_b, making read latency 2 cycles.
  - Stage advances only when the corresponding en was high one cycle earlier; otherwise it holds.
  - Reset clears the stage to 0.
  - collision is delayed one extra cycle to stay aligned with the data.
- Undefined: read latency 1 cycle, as specified above.

Test Plan (defaults DATA_W=8, ADDR_W=5, RD_MODE=0, INIT_VAL=0):
1. Release reset -> init_busy high for exactly 32 cycles then 0; then read all 32 addresses on A and B -> every word 0x00.
2. Simultaneous write A addr5=0xAB and B addr10=0x33, then read A@10 and B@5 -> q_a=0x33, q_b=0xAB one cycle after the read; collision=0 throughout.
3. Both ports write addr7 (A=0xCA, B=0x27) -> collision=1 for one cycle; subsequent read of addr7 -> 0xCA.
4. Addr9=0x11; A writes 0x55 to addr9 while B reads addr9 -> q_b=0x11, q_a=0x11, collision pulse. Repeat with RD_MODE=1 -> q_a=0x55, q_b=0x11.
5. Write addr3=0x5A, deassert en_a for 4 cycles with addr/data toggling -> q_a stable, addr3 unchanged. Assert reset mid-run -> init_busy re-asserts and addr3 reads 0x00 after the sweep.
6. With OUTPUT_REG_EN defined, read addr5=0xAB -> q_a=0xAB two cycles after the request edge; a same-address write collision pulses two cycles after its edge.

Source files
------------

// File: rtl/dual_port_ram_param.sv
// dual_port_ram_param: parametrised true dual-port synchronous RAM.
// Both ports run on one clock, and each port has its own enable.
// Same-port read-during-write behaviour is selected by RD_MODE.
// When both ports hit the same address on one edge, port A's write wins and the
// collision flag pulses.
// A post-reset sweep writes INIT_VAL to every word before any port access is allowed.
// Optional macro OUTPUT_REG_EN: adds an output pipeline stage (read latency 2).
module dual_port_ram_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RD_MODE  = 0,
  parameter int unsigned INIT_VAL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_a,
  input  logic              wr_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] q_a,
  input  logic              en_b,
  input  logic              wr_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_b,
  output logic              init_busy,
  output logic              collision
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] INIT_WORD = DATA_W'(INIT_VAL);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   init_cnt;
  logic                init_busy_r;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   q_a_r;
  logic [DATA_W-1:0]   q_b_r;
  logic                collision_r;

  logic                run;
  logic                init_we;
  logic                we_a;
  logic                we_b;
  logic                conflict;

  // Access qualifiers. Port requests count only in RUN and only when reset is low.
  always_comb begin
    run      = !reset && (state == ST_RUN);
    init_we  = !reset && (state == ST_INIT);
    we_a     = run && en_a && wr_a;
    we_b     = run && en_b && wr_b;
    conflict = en_a && en_b && (addr_a == addr_b) && (wr_a || wr_b);
  end

  // Init sequencer. It sweeps the counter once after reset, then stays in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      init_busy_r <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + ADDR_W'(1);
          if (init_cnt == LAST_ADDR) begin
            state       <= ST_RUN;
            init_busy_r <= 1'b0;
          end
        end
        default: begin
          state       <= ST_RUN;
          init_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Memory array. Port A's write is issued last so it wins a same-address write.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt] <= INIT_WORD;
    end else begin
      if (we_b) mem[addr_b] <= data_b;
      if (we_a) mem[addr_a] <= data_a;
    end
  end

  // Registered read data and collision flag.
  // A reading port always sees the pre-edge word, so cross-port reads are read-first.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_a_r       <= '0;
      q_b_r       <= '0;
      collision_r <= 1'b0;
    end else if (state == ST_RUN) begin
      if (en_a) q_a_r <= (wr_a && (RD_MODE != 0)) ? data_a : mem[addr_a];
      if (en_b) q_b_r <= (wr_b && (RD_MODE != 0)) ? data_b : mem[addr_b];
      collision_r <= conflict;
    end else begin
      collision_r <= 1'b0;
    end
  end

`ifdef OUTPUT_REG_EN
  logic              en_a_d;
  logic              en_b_d;
  logic [DATA_W-1:0] q_a_p;
  logic [DATA_W-1:0] q_b_p;
  logic              collision_p;

  // Output pipeline stage. Each side advances only after an accepted access on its port.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_a_d      <= 1'b0;
      en_b_d      <= 1'b0;
      q_a_p       <= '0;
      q_b_p       <= '0;
      collision_p <= 1'b0;
    end else begin
      en_a_d      <= run && en_a;
      en_b_d      <= run && en_b;
      collision_p <= collision_r;
      if (en_a_d) q_a_p <= q_a_r;
      if (en_b_d) q_b_p <= q_b_r;
    end
  end

  assign q_a       = q_a_p;
  assign q_b       = q_b_p;
  assign collision = collision_p;
`else
  assign q_a       = q_a_r;
  assign q_b       = q_b_r;
  assign collision = collision_r;
`endif

  assign init_busy = init_busy_r;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Testbench for dual_port_ram_param.
// Two instances share one set of stimulus: dut0 uses read-first mode and dut1 uses write-first mode.
// Expected values are computed by hand and stored in the vector table.
module tb_dual_port_ram_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_a, wr_a, en_b, wr_b;
  logic [4:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic [7:0] q_a0, q_b0, q_a1, q_b1;
  logic       busy0, busy1, col0, col1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_port_ram_param #(.DATA_W(8), .ADDR_W(5), .RD_MODE(0), .INIT_VAL(0)) dut0 (
    .clk(clk), .reset(reset),
    .en_a(en_a), .wr_a(wr_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a0),
    .en_b(en_b), .wr_b(wr_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b0),
    .init_busy(busy0), .collision(col0)
  );

  dual_port_ram_param #(.DATA_W(8), .ADDR_W(5), .RD_MODE(1), .INIT_VAL(0)) dut1 (
    .clk(clk), .reset(reset),
    .en_a(en_a), .wr_a(wr_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a1),
    .en_b(en_b), .wr_b(wr_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b1),
    .init_busy(busy1), .collision(col1)
  );

  typedef struct {
    logic       ea, wa;
    logic [4:0] aa;
    logic [7:0] da;
    logic       eb, wb;
    logic [4:0] ab;
    logic [7:0] db;
    logic [7:0] qa0, qb0, qa1, qb1;
    logic       col;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    en_a = 1'b0; wr_a = 1'b0; addr_a = '0; data_a = '0;
    en_b = 1'b0; wr_b = 1'b0; addr_b = '0; data_b = '0;
  endtask

  // Apply one request at one edge and sample once the data is visible.
  task automatic step(input logic ea, input logic wa, input logic [4:0] aa, input logic [7:0] da,
                      input logic eb, input logic wb, input logic [4:0] ab, input logic [7:0] db);
    @(negedge clk);
    en_a = ea; wr_a = wa; addr_a = aa; data_a = da;
    en_b = eb; wr_b = wb; addr_b = ab; data_b = db;
    @(posedge clk);
`ifdef OUTPUT_REG_EN
    @(negedge clk);
    idle();
    @(posedge clk);
`endif
    #1;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy0 && n < 100);
    check({name, "_cycles"}, n, 32);
    check({name, "_busy1"}, busy1, 1'b0);
  endtask

  task automatic set_vec(input int i, input logic ea, input logic wa, input logic [4:0] aa,
                         input logic [7:0] da, input logic eb, input logic wb, input logic [4:0] ab,
                         input logic [7:0] db, input logic [7:0] qa0, input logic [7:0] qb0,
                         input logic [7:0] qa1, input logic [7:0] qb1, input logic col);
    vecs[i] = '{ea, wa, aa, da, eb, wb, ab, db, qa0, qb0, qa1, qb1, col};
  endtask

  initial begin
    //       ea wa aa     da     eb wb ab     db     qa0    qb0    qa1    qb1    col
    set_vec(0,  1, 1, 5'd5,  8'hAB, 1, 1, 5'd10, 8'h33, 8'h00, 8'h00, 8'hAB, 8'h33, 0);
    set_vec(1,  1, 0, 5'd10, 8'h00, 1, 0, 5'd5,  8'h00, 8'h33, 8'hAB, 8'h33, 8'hAB, 0);
    set_vec(2,  1, 1, 5'd7,  8'hCA, 1, 1, 5'd7,  8'h27, 8'h00, 8'h00, 8'hCA, 8'h27, 1);
    set_vec(3,  1, 0, 5'd7,  8'h00, 1, 0, 5'd7,  8'h00, 8'hCA, 8'hCA, 8'hCA, 8'hCA, 0);
    set_vec(4,  1, 1, 5'd9,  8'h11, 0, 0, 5'd0,  8'h00, 8'h00, 8'hCA, 8'h11, 8'hCA, 0);
    set_vec(5,  1, 1, 5'd9,  8'h55, 1, 0, 5'd9,  8'h00, 8'h11, 8'h11, 8'h55, 8'h11, 1);
    set_vec(6,  1, 0, 5'd9,  8'h00, 1, 0, 5'd9,  8'h00, 8'h55, 8'h55, 8'h55, 8'h55, 0);
    set_vec(7,  1, 0, 5'd9,  8'h00, 1, 1, 5'd9,  8'h66, 8'h55, 8'h55, 8'h55, 8'h66, 1);
    set_vec(8,  1, 1, 5'd3,  8'h5A, 1, 0, 5'd9,  8'h00, 8'h00, 8'h66, 8'h5A, 8'h66, 0);
    set_vec(9,  0, 1, 5'd3,  8'hFF, 0, 0, 5'd0,  8'h00, 8'h00, 8'h66, 8'h5A, 8'h66, 0);
    set_vec(10, 0, 1, 5'd4,  8'h00, 0, 0, 5'd0,  8'h00, 8'h00, 8'h66, 8'h5A, 8'h66, 0);
    set_vec(11, 0, 1, 5'd3,  8'hFF, 0, 0, 5'd0,  8'h00, 8'h00, 8'h66, 8'h5A, 8'h66, 0);
    set_vec(12, 0, 1, 5'd4,  8'h00, 0, 0, 5'd0,  8'h00, 8'h00, 8'h66, 8'h5A, 8'h66, 0);
    set_vec(13, 1, 0, 5'd3,  8'h00, 1, 0, 5'd4,  8'h00, 8'h5A, 8'h00, 8'h5A, 8'h00, 0);
    set_vec(14, 1, 0, 5'd31, 8'h00, 0, 1, 5'd3,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    set_vec(15, 1, 0, 5'd3,  8'h00, 1, 0, 5'd31, 8'h00, 8'h5A, 8'h00, 8'h5A, 8'h00, 0);

    // Reset, then the init sweep with port traffic that must be ignored.
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 1'b1);
    check("rst_qa", q_a0, 8'h00);
    check("rst_qb", q_b0, 8'h00);
    check("rst_col", col0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    en_a = 1'b1; wr_a = 1'b1; addr_a = 5'd3; data_a = 8'hFF;
    en_b = 1'b1; wr_b = 1'b1; addr_b = 5'd3; data_b = 8'hEE;
    wait_init("init");
    check("init_qa_held", q_a0, 8'h00);
    check("init_col", col0, 1'b0);
    @(negedge clk);
    idle();

    // Every word must read back as the init value on both ports.
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 5'(i), 8'h00, 1, 0, 5'(31 - i), 8'h00);
      check($sformatf("sweep_qa_%0d", i), q_a0, 8'h00);
      check($sformatf("sweep_qb_%0d", 31 - i), q_b1, 8'h00);
    end

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].ea, vecs[i].wa, vecs[i].aa, vecs[i].da,
           vecs[i].eb, vecs[i].wb, vecs[i].ab, vecs[i].db);
      check($sformatf("v%0d_qa0", i), q_a0, vecs[i].qa0);
      check($sformatf("v%0d_qb0", i), q_b0, vecs[i].qb0);
      check($sformatf("v%0d_qa1", i), q_a1, vecs[i].qa1);
      check($sformatf("v%0d_qb1", i), q_b1, vecs[i].qb1);
      check($sformatf("v%0d_col", i), col0, vecs[i].col);
      check($sformatf("v%0d_col1", i), col1, vecs[i].col);
    end

    // A reset during RUN restarts the sweep, so addr3 must be cleared again.
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rerst_busy", busy0, 1'b1);
    check("rerst_qa", q_a0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    wait_init("reinit");
    step(1, 0, 5'd3, 8'h00, 1, 0, 5'd3, 8'h00);
    check("rerst_addr3_a", q_a0, 8'h00);
    check("rerst_addr3_b", q_b1, 8'h00);

    // Latency sequence: write addr5, then observe the read and a collision edge by edge.
    step(1, 1, 5'd5, 8'hAB, 0, 0, 5'd0, 8'h00);
    @(negedge clk);
    en_a = 1'b1; wr_a = 1'b0; addr_a = 5'd5;
    @(posedge clk);
    #1;
`ifdef OUTPUT_REG_EN
    check("lat_qa_edge1", q_a0, 8'h00);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
`endif
    check("lat_qa", q_a0, 8'hAB);
    @(negedge clk);
    en_a = 1'b1; wr_a = 1'b1; addr_a = 5'd5; data_a = 8'h01;
    en_b = 1'b1; wr_b = 1'b1; addr_b = 5'd5; data_b = 8'h02;
    @(posedge clk);
    #1;
`ifdef OUTPUT_REG_EN
    check("lat_col_edge1", col0, 1'b0);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
`endif
    check("lat_col_pulse", col0, 1'b1);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    check("lat_col_clear", col0, 1'b0);
    step(1, 0, 5'd5, 8'h00, 0, 0, 5'd0, 8'h00);
    check("lat_a_wins", q_a0, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
